// File: rtl/sodor_resp_addr_tracker.sv
// In-order tracker of outstanding core request addresses.
// The oldest address steers each response back through the router.
module sodor_resp_addr_tracker #(
   parameter int DEPTH   = 2,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     io_req_valid,
   input  logic [ADDR_W-1:0]        io_req_bits_addr,
   input  logic                     io_req_bits_fcn,
   input  logic                     io_router_req_ready,
   output logic                     io_req_ready,
   input  logic                     io_resp_valid,
   output logic [ADDR_W-1:0]        io_respAddress,
   output logic                     io_respIsWrite,
   output logic [$clog2(DEPTH):0]   io_outstanding,
   output logic                     io_empty,
   output logic                     io_full,
   output logic                     io_err_spurious,
   output logic                     io_err_timeout
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

   logic [ADDR_W-1:0] addrMem [DEPTH];
   logic              fcnMem  [DEPTH];

   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  countNext;
   logic [TMR_W-1:0]  timer;
   logic              resetReleased;
   logic              errSpurious;
   logic              errTimeout;
   logic              push;
   logic              pop;

   assign io_empty       = (count == '0);
   assign io_full        = (count == FULL_CNT);
   assign io_outstanding = count;

   // Ready ignores io_resp_valid so response never combinationally feeds ready.
   assign io_req_ready = io_router_req_ready & ~io_full & resetReleased;

   assign push = io_req_valid & io_req_ready;
   assign pop  = io_resp_valid & ~io_empty;

   assign io_respAddress  = io_empty ? '0 : addrMem[rdPtr];
   assign io_respIsWrite  = io_empty ? 1'b0 : fcnMem[rdPtr];
   assign io_err_spurious = errSpurious;
   assign io_err_timeout  = errTimeout;

   always_comb begin
      countNext = count;
      case ({push, pop})
         2'b10:   countNext = count + CNT_W'(1);
         2'b01:   countNext = count - CNT_W'(1);
         default: countNext = count;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) begin
         addrMem[wrPtr] <= io_req_bits_addr;
         fcnMem[wrPtr]  <= io_req_bits_fcn;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrPtr         <= '0;
         rdPtr         <= '0;
         count         <= '0;
         timer         <= '0;
         resetReleased <= 1'b0;
         errSpurious   <= 1'b0;
         errTimeout    <= 1'b0;
      end else begin
         resetReleased <= 1'b1;
         count         <= countNext;
         if (push)
            wrPtr <= wrPtr + PTR_W'(1);
         if (pop)
            rdPtr <= rdPtr + PTR_W'(1);
         // Head age: restarts on every pop, idles at zero when drained.
         if (pop || countNext == '0)
            timer <= '0;
         else if (timer != TMR_MAX)
            timer <= timer + TMR_W'(1);
         if (io_resp_valid && io_empty)
            errSpurious <= 1'b1;
         if (!io_empty && !pop && timer == TMR_MAX)
            errTimeout <= 1'b1;
      end
   end

endmodule

// File: doc/sodor_resp_addr_tracker.md
Name: sodor_resp_addr_tracker

Overview:
- Sits between the core's memory request/response port and the scratchpad/master request router.
- Records the address of every accepted core request in a small in-order FIFO.
- Presents the oldest outstanding address to the router as its response-steering address, so each response is routed to the port that owns that address.
- Throttles core request acceptance when the FIFO is full; flags protocol errors (spurious response, response timeout).

Parameters:
DEPTH, 2, number of outstanding requests tracked; power of two, >= 2
ADDR_W, 32, request address width
TIMEOUT, 255, cycles the head entry may wait for a response before the timeout flag sets; >= 1

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
io_req_valid  input  1  core request valid
io_req_bits_addr  input  ADDR_W  core request address
io_req_bits_fcn  input  1  core request function, 1 = write
io_router_req_ready  input  1  ready from the router's core-side request port
io_req_ready  output  1  gated ready returned to the core
io_resp_valid  input  1  response valid from the router's core-side response port
io_respAddress  output  ADDR_W  head-entry address, driven to the router's response-address input
io_respIsWrite  output  1  head-entry fcn
io_outstanding  output  log2(DEPTH)+1  current occupancy
io_empty  output  1  occupancy == 0
io_full  output  1  occupancy == DEPTH
io_err_spurious  output  1  sticky: response arrived with FIFO empty
io_err_timeout  output  1  sticky: head waited TIMEOUT cycles

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release):
  - wr_ptr = rd_ptr = 0; count = 0; timer = 0; both error flags 0.
  - Outputs: io_empty = 1, io_full = 0, io_outstanding = 0, io_respAddress = 0, io_respIsWrite = 0, io_req_ready = 0.
  - Reset asserted mid-transaction discards all entries; no pending response is honoured after release.
- Ready: io_req_ready = io_router_req_ready & ~io_full & reset_released.
  - Purely combinational from its inputs and registered state.
  - Does not depend on io_resp_valid, so there is no comb path from response to ready; a full FIFO stalls one cycle even if a pop occurs that cycle.
- Push: push = io_req_valid & io_req_ready.
  - On the clock edge, writes {addr, fcn} at wr_ptr; wr_ptr increments modulo DEPTH (wraps to 0).
- Pop: pop = io_resp_valid & ~io_empty.
  - On the clock edge, rd_ptr increments modulo DEPTH.
- Head outputs:
  - io_respAddress and io_respIsWrite show the entry at rd_ptr combinationally (zero latency) while non-empty; both are 0 when empty.
  - A request pushed in cycle N becomes head no earlier than cycle N+1, so a response is never steered by a same-cycle request.
- Occupancy:
  - count += push - pop; simultaneous push and pop leaves count unchanged.
  - count never exceeds DEPTH and never underflows.
  - io_outstanding = count.
- Spurious response: io_resp_valid while empty causes no pop and sets io_err_spurious next cycle. The flag is sticky until reset.
- Timer:
  - Clears to 0 on any pop, and while empty.
  - Otherwise increments each cycle, saturating at TIMEOUT.
  - When timer == TIMEOUT and no pop occurs that cycle, io_err_timeout sets next cycle. The flag is sticky until reset.
  - The timer resets to 0 when a new entry becomes head after a pop.
- Entries are never dropped on error; the FIFO continues operating normally.
- Writes produce responses exactly like reads and are popped identically.

Test Plan:
- Single read: push addr 0x8000_0100, resp_valid next cycle → io_respAddress = 0x8000_0100 in that cycle; then io_empty = 1 and io_respAddress = 0.
- Fill (DEPTH = 2), router ready held 1: push 0x8000_0000 then 0x0000_1000 → io_full = 1, io_req_ready = 0. Third request stalls until the cycle after one pop; head order is preserved (0x8000_0000, then 0x0000_1000).
- Simultaneous push and pop at count = 1, repeated for 8 cycles with incrementing addresses → io_outstanding stays 1; pointers wrap past DEPTH-1; each popped address equals the one pushed the previous cycle.
- Spurious: resp_valid with FIFO empty → io_err_spurious = 1 next cycle and stays 1; io_outstanding stays 0; a subsequent normal push/pop is unaffected.
- Timeout (TIMEOUT = 4): push one request, no response → io_err_timeout = 0 through the 4th waiting cycle and 1 thereafter. A response arriving later still pops, and the flag stays set.
- Async reset mid-flight: push 2 entries, pull reset low between clock edges → all outputs go to reset values immediately. After release, io_empty = 1 and a resp_valid sets io_err_spurious.
